alu_div_sequencer: RTL and testbench

//  Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. Drives the shared combinational ALU
//  (a, b, alu_op -> result, carry_out) one SUB per cycle to run restoring division.

---
 rtl/alu_div_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_div_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer.
// Runs restoring division by borrowing the shared EX-stage ALU for one SUB per cycle.
// Signed operands are reduced to magnitudes first, and the signs are put back at the end.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; in_ready=1
// NEG_A  | absolute value of the dividend into q_reg (via 0 - x)
// NEG_B  | absolute value of the divisor into d_reg; clears the partial remainder
// ITER   | one restoring-division step per cycle, XLEN cycles in total
// FIX_Q  | applies the quotient sign and registers the quotient
// FIX_R  | applies the remainder sign and registers the remainder
// DONE   | out_valid=1; held until out_ready
module alu_div_sequencer #(
  parameter int          XLEN       = 32,
  parameter logic [3:0]  ALU_OP_SUB = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            in_ready,
  input  logic            op_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero,
  output logic            busy,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_carry_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_Q, S_FIX_R, S_DONE
  } state_t;

  state_t          state;
  logic [XLEN-1:0] q_reg;
  logic [XLEN-1:0] d_reg;
  logic [XLEN-1:0] r_reg;
  logic [CW-1:0]   count;
  logic            signed_op;
  logic            sign_q;
  logic            sign_r;

  logic [XLEN-1:0] sh;
  logic            r_hi;

  // Shifted partial remainder for the current division step; r_hi is the bit shifted out.
  always_comb begin
    sh   = {r_reg[XLEN-2:0], q_reg[XLEN-1]};
    r_hi = r_reg[XLEN-1];
  end

  // ALU operand steering. Negation is computed as 0 - x, so alu_a stays 0 outside ITER.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 4'b0000;
    case (state)
      S_NEG_A: begin alu_b = q_reg; alu_op = ALU_OP_SUB; end
      S_NEG_B: begin alu_b = d_reg; alu_op = ALU_OP_SUB; end
      S_ITER:  begin alu_a = sh; alu_b = d_reg; alu_op = ALU_OP_SUB; end
      S_FIX_Q: begin alu_b = q_reg; alu_op = ALU_OP_SUB; end
      S_FIX_R: begin alu_b = r_reg; alu_op = ALU_OP_SUB; end
      default: ;
    endcase
  end

  // Sequencer FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      signed_op   <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= ALL_ONES;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end else if (op_signed && dividend == MIN_INT && divisor == ALL_ONES) begin
              // Signed overflow: the quotient wraps to the dividend itself.
              quotient    <= MIN_INT;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end else begin
              q_reg     <= dividend;
              d_reg     <= divisor;
              signed_op <= op_signed;
              sign_q    <= op_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
              sign_r    <= op_signed & dividend[XLEN-1];
              busy      <= 1'b1;
              state     <= S_NEG_A;
            end
          end
        end
        S_NEG_A: begin
          if (signed_op && q_reg[XLEN-1]) q_reg <= alu_result;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (signed_op && d_reg[XLEN-1]) d_reg <= alu_result;
          r_reg <= '0;
          count <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          // When the shifted-out bit is set, the true remainder is at least 2^XLEN > d_reg.
          if (alu_carry_out || r_hi) begin
            r_reg <= alu_result;
            q_reg <= {q_reg[XLEN-2:0], 1'b1};
          end else begin
            r_reg <= sh;
            q_reg <= {q_reg[XLEN-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(XLEN - 1)) state <= S_FIX_Q;
        end
        S_FIX_Q: begin
          quotient <= sign_q ? alu_result : q_reg;
          state    <= S_FIX_R;
        end
        S_FIX_R: begin
          remainder   <= sign_r ? alu_result : r_reg;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          out_valid   <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Self-checking bench for alu_div_sequencer: directed corner cases plus random operations,
// checked against an arithmetic reference model. The bench also models the shared ALU.
module tb_alu_div_sequencer;

  localparam int XLEN = 32;
  localparam logic [3:0] SUB = 4'b1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            in_ready;
  logic            op_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_by_zero;
  logic            busy;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_carry_out;

  int n_checks = 0;
  int n_errors = 0;

  alu_div_sequencer #(.XLEN(XLEN), .ALU_OP_SUB(SUB)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carry_out(alu_carry_out)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU: a SUB, with carry_out meaning no borrow.
  always_comb begin
    alu_result    = alu_a - alu_b;
    alu_carry_out = (alu_a >= alu_b);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // RV32M reference semantics, computed directly from the instruction definition.
  task automatic ref_div(input logic sgn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         output logic [XLEN-1:0] q, output logic [XLEN-1:0] r,
                         output logic dz, output bit special);
    int sa, sb;
    dz = 0; special = 0;
    if (b == 0) begin
      q = '1; r = a; dz = 1; special = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; special = 1;
    end else if (sgn) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  task automatic run_op(input logic sgn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int hold);
    logic [XLEN-1:0] eq, er;
    logic edz;
    bit spc;
    int k;
    ref_div(sgn, a, b, eq, er, edz, spc);
    chk("in_ready_before", in_ready, 1);
    start = 1; op_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 0;
    k = 1;
    while (!out_valid && k < 100) begin
      if (k == 1) begin
        chk("busy_running", busy, 1);
        chk("alu_op_running", alu_op, SUB);
      end
      // A start while not ready must be ignored and must not disturb the operands.
      if (k == 3) begin
        start = 1; op_signed = ~sgn; dividend = $urandom; divisor = $urandom;
      end
      if (k == 4) start = 0;
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    chk("latency", k, spc ? 1 : XLEN + 5);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    chk("busy_done", busy, 0);
    chk("alu_op_done", alu_op, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_quotient", quotient, eq);
        chk("hold_remainder", remainder, er);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    logic [XLEN-1:0] ra, rb;
    logic rs;
    rst = 1; start = 0; op_signed = 0; dividend = 0; divisor = 0; out_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);

    run_op(0, 100, 7, 10);
    run_op(1, 32'hFFFF_FFF9, 2, 0);
    run_op(0, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(0, 5, 0, 3);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1, 7, 32'hFFFF_FFFE, 0);
    run_op(1, 32'h8000_0000, 1, 0);
    run_op(1, 32'hFFFF_FFF9, 0, 0);

    // Reset in the middle of ITER aborts the operation.
    start = 1; op_signed = 0; dividend = 1000; divisor = 3;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_iter_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_alu_op", alu_op, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_result", out_valid, 0);

    for (int n = 0; n < 40; n++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 0;
        1: rb = $urandom_range(1, 15);
        2: rb = -$urandom_range(1, 15);
        3: begin ra = 32'h8000_0000; rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(rs, ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
